fir_tap_chain: RTL and testbench

Parametrised transposed-form FIR filter built from a chain of TAPS multiply-accumulate slices, with a run-time coefficient load port, a valid/ready sample interface, an output scaling shift and saturation. It supersedes single fixed-width DSP slices in the modulator's pulse-shaping path. It sits between the QAM symbol mapper (per-rail samples) and the DAC formatter, with one instance per I/Q rail.

---
 rtl/fir_tap_chain.sv | 161 ++++++++++++++++
 tb/tb_fir_tap_chain.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_chain.sv
// Transposed-form FIR tap chain: run-time coefficient reload, valid/ready
// sample input, output right shift with saturation to OUT_W bits.
// Define FIR_ROUND_EN for round-half-up on the output shift (default: truncate).
module fir_tap_chain #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned COEF_W = 8,
   parameter int unsigned TAPS   = 8,
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned OUT_W  = 12,
   parameter int unsigned SHIFT  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x_in,
   input  logic              coef_start,
   input  logic              coef_wr,
   input  logic [COEF_W-1:0] coef_data,
   output logic              coef_done,
   output logic              y_valid,
   output logic [OUT_W-1:0]  y_out,
   output logic              sat_flag
);

   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam int unsigned IDX_W  = $clog2(TAPS);
   localparam int unsigned SH_W   = ACC_W + 1;
   localparam int unsigned RND_I  = (2 ** SHIFT) / 2;
   localparam logic [SH_W-1:0] Y_MAX = SH_W'((2 ** OUT_W) - 1);

   // Parameter sanity: the chain must never overflow its partial sums.
   if (ACC_W < DATA_W + COEF_W + $clog2(TAPS)) begin : g_bad_acc_w
      $error("fir_tap_chain: ACC_W too small for DATA_W+COEF_W+clog2(TAPS)");
   end
   if (TAPS < 2) begin : g_bad_taps
      $error("fir_tap_chain: TAPS must be at least 2");
   end
   if (SHIFT >= ACC_W) begin : g_bad_shift
      $error("fir_tap_chain: SHIFT must be below ACC_W");
   end

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_LOAD = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [COEF_W-1:0] r_coef [TAPS];
   logic [ACC_W-1:0]  r_s    [1:TAPS-1];
   logic [PROD_W-1:0] w_prod [TAPS];
   logic [ACC_W-1:0]  w_full;
   logic [SH_W-1:0]   w_shifted;
   logic              w_sat;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_load_wr;
   logic              w_load_last;
   logic              r_y_valid;
   logic [OUT_W-1:0]  r_y_out;
   logic              r_sat;
   logic              r_coef_done;

   // Coefficient FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state: start a reload from IDLE, return after the last write.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (coef_start) w_state_nxt = S_LOAD;
         S_LOAD:  if (coef_wr && (r_idx == IDX_W'(TAPS - 1))) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM decodes: sample acceptance and coefficient write strobes.
   always_comb begin
      w_in_ready  = (r_state == S_IDLE);
      w_load_wr   = (r_state == S_LOAD) && coef_wr;
      w_load_last = w_load_wr && (r_idx == IDX_W'(TAPS - 1));
      w_accept    = in_valid && w_in_ready;
   end

   // Write index into the coefficient bank.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if ((r_state == S_IDLE) && coef_start) begin
         r_idx <= '0;
      end else if (w_load_wr) begin
         r_idx <= w_load_last ? '0 : r_idx + IDX_W'(1);
      end
   end

   // Per-tap products and the full sum leaving the head of the chain.
   always_comb begin
      for (int k = 0; k < TAPS; k++) begin
         w_prod[k] = PROD_W'(r_coef[k]) * PROD_W'(x_in);
      end
      w_full = ACC_W'(w_prod[0]) + r_s[1];
   end

   // Output scaling and saturation.
   always_comb begin
`ifdef FIR_ROUND_EN
      w_shifted = ({1'b0, w_full} + SH_W'(RND_I)) >> SHIFT;
`else
      w_shifted = {1'b0, w_full} >> SHIFT;
`endif
      w_sat = (OUT_W < SH_W) ? (w_shifted > Y_MAX) : 1'b0;
   end

   // Coefficient bank and partial-sum chain; a completed reload clears history.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) r_coef[k] <= '0;
         for (int k = 1; k < TAPS; k++) r_s[k] <= '0;
      end else begin
         if (w_load_wr) begin
            for (int k = 0; k < TAPS; k++) begin
               if (r_idx == IDX_W'(k)) r_coef[k] <= coef_data;
            end
         end
         if (w_load_last) begin
            for (int k = 1; k < TAPS; k++) r_s[k] <= '0;
         end else if (w_accept) begin
            for (int k = 1; k < TAPS - 1; k++) begin
               r_s[k] <= ACC_W'(w_prod[k]) + r_s[k+1];
            end
            r_s[TAPS-1] <= ACC_W'(w_prod[TAPS-1]);
         end
      end
   end

   // Output register: one-cycle valid, held result and saturation flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_y_valid   <= 1'b0;
         r_y_out     <= '0;
         r_sat       <= 1'b0;
         r_coef_done <= 1'b0;
      end else begin
         r_y_valid   <= w_accept;
         r_coef_done <= w_load_last;
         if (w_accept) begin
            r_y_out <= w_sat ? {OUT_W{1'b1}} : OUT_W'(w_shifted);
            r_sat   <= w_sat;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign y_valid   = r_y_valid;
   assign y_out     = r_y_out;
   assign sat_flag  = r_sat;
   assign coef_done = r_coef_done;

endmodule

// File: tb/tb_fir_tap_chain.sv
// Bench for fir_tap_chain (TAPS=4): two instances share stimulus, one with
// SHIFT=0 and one with SHIFT=2, both checked against a direct-form model.
module tb_fir_tap_chain;

   localparam int unsigned TAPS = 4;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, coef_start, coef_wr;
   logic [3:0] x_in;
   logic [7:0] coef_data;

   logic        rdy0, done0, yv0, sat0;
   logic [11:0] y0;
   logic        rdy2, done2, yv2, sat2;
   logic [11:0] y2;

   int n_chk = 0;
   int n_err = 0;

   // Model state: coefficients, newest-first sample history, reload progress.
   int m_c [TAPS];
   int m_h [TAPS];
   bit m_load;
   int m_idx;
   bit e_yv, e_done, e_s0, e_s2;
   int e_y0, e_y2;

   always #5 clk = ~clk;

   fir_tap_chain #(.DATA_W(4), .COEF_W(8), .TAPS(TAPS), .ACC_W(16), .OUT_W(12), .SHIFT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .x_in(x_in),
      .coef_start(coef_start), .coef_wr(coef_wr), .coef_data(coef_data), .coef_done(done0),
      .y_valid(yv0), .y_out(y0), .sat_flag(sat0));

   fir_tap_chain #(.DATA_W(4), .COEF_W(8), .TAPS(TAPS), .ACC_W(16), .OUT_W(12), .SHIFT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .x_in(x_in),
      .coef_start(coef_start), .coef_wr(coef_wr), .coef_data(coef_data), .coef_done(done2),
      .y_valid(yv2), .y_out(y2), .sat_flag(sat2));

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scale and clip a full sum the way the output stage is defined to.
   task automatic scale(input int full, input int sh, output int y, output bit s);
      int r;
`ifdef FIR_ROUND_EN
      r = (sh == 0) ? full : ((full + (1 << (sh - 1))) >> sh);
`else
      r = full >> sh;
`endif
      s = (r > 4095);
      y = s ? 4095 : r;
   endtask

   // Advance the model by one clock edge using the current inputs.
   task automatic model_edge();
      int full;
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) begin m_c[k] = 0; m_h[k] = 0; end
         m_load = 0; m_idx = 0;
         e_yv = 0; e_done = 0; e_y0 = 0; e_y2 = 0; e_s0 = 0; e_s2 = 0;
         return;
      end
      e_yv = 0; e_done = 0;
      if (in_valid && !m_load) begin
         for (int k = TAPS - 1; k > 0; k--) m_h[k] = m_h[k-1];
         m_h[0] = int'(x_in);
         full = 0;
         for (int k = 0; k < TAPS; k++) full += m_c[k] * m_h[k];
         scale(full, 0, e_y0, e_s0);
         scale(full, 2, e_y2, e_s2);
         e_yv = 1;
      end
      if (!m_load) begin
         if (coef_start) begin m_load = 1; m_idx = 0; end
      end else if (coef_wr) begin
         m_c[m_idx] = int'(coef_data);
         if (m_idx == TAPS - 1) begin
            m_load = 0;
            for (int k = 0; k < TAPS; k++) m_h[k] = 0;
            e_done = 1;
         end else begin
            m_idx++;
         end
      end
   endtask

   // Drive one cycle, update the model, sample 1 time unit after the edge.
   task automatic cyc(input bit rn, input bit v, input bit cs, input bit cw,
                      input logic [3:0] x, input logic [7:0] cd);
      rst_n = rn; in_valid = v; coef_start = cs; coef_wr = cw; x_in = x; coef_data = cd;
      model_edge();
      @(posedge clk);
      #1;
      check("in_ready0", int'(rdy0), int'(!m_load));
      check("in_ready2", int'(rdy2), int'(!m_load));
      check("coef_done", int'(done0), int'(e_done));
      check("y_valid0", int'(yv0), int'(e_yv));
      check("y_valid2", int'(yv2), int'(e_yv));
      check("y_out0", int'(y0), e_y0);
      check("sat0", int'(sat0), int'(e_s0));
      check("y_out2", int'(y2), e_y2);
      check("sat2", int'(sat2), int'(e_s2));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 4'd0, 8'd0);
   endtask

   // Reload four coefficients; optional gaps hold in_valid high and retry coef_start.
   task automatic load4(input int c0, input int c1, input int c2, input int c3, input bit gaps);
      int c [TAPS];
      c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
      cyc(1, 0, 1, 0, 4'd0, 8'd0);
      for (int k = 0; k < TAPS; k++) begin
         if (gaps) begin
            for (int g = 0; g < 2; g++) begin
               cyc(1, 1, 1'($urandom_range(0, 1)), 0, 4'($urandom), 8'($urandom));
               check("held_off", int'(yv0), 0);
            end
         end
         cyc(1, 0, 0, 1, 4'd0, 8'(c[k]));
      end
   endtask

   int imp_exp [5] = '{1, 2, 3, 4, 0};
   int imp_x   [5] = '{1, 0, 0, 0, 0};
   int rnd_exp;

   initial begin
      rst_n = 0; in_valid = 0; coef_start = 0; coef_wr = 0; x_in = '0; coef_data = '0;

      // Reset state.
      cyc(0, 0, 0, 0, 4'd0, 8'd0);
      cyc(0, 0, 0, 0, 4'd0, 8'd0);
      idle(1);

      // Impulse response, back to back.
      load4(1, 2, 3, 4, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 1, 0, 0, 4'(imp_x[i]), 8'd0);
         check("imp_y", int'(y0), imp_exp[i]);
      end
      idle(2);

      // Saturation with full-scale coefficients and samples.
      load4(255, 255, 255, 255, 0);
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 0, 0, 4'd15, 8'd0);
         check("sat_y", int'(y0), (i == 0) ? 3825 : 4095);
         check("sat_flag", int'(sat0), (i == 0) ? 0 : 1);
      end
      idle(2);

      // Impulse with random idle gaps.
      load4(1, 2, 3, 4, 0);
      for (int i = 0; i < 5; i++) begin
         for (int g = $urandom_range(0, 3); g > 0; g--) cyc(1, 0, 0, 0, 4'($urandom), 8'd0);
         cyc(1, 1, 0, 0, 4'(imp_x[i]), 8'd0);
         check("gap_y", int'(y0), imp_exp[i]);
      end
      idle(2);

      // Reload mid-stream clears history.
      load4(1, 1, 1, 1, 0);
      for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 4'd1, 8'd0);
      check("stream_y", int'(y0), 4);
      load4(2, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 4'd1, 8'd0);
      check("reload_y", int'(y0), 2);
      idle(2);

      // Reset in the middle of a reload.
      cyc(1, 0, 1, 0, 4'd0, 8'd0);
      cyc(1, 0, 0, 1, 4'd0, 8'd9);
      cyc(1, 0, 0, 1, 4'd0, 8'd9);
      cyc(0, 0, 0, 0, 4'd0, 8'd0);
      check("rst_ready", int'(rdy0), 1);
      cyc(1, 1, 0, 0, 4'd5, 8'd0);
      check("rst_y", int'(y0), 0);
      idle(1);

      // Rounding on the SHIFT=2 instance.
      load4(6, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 4'd1, 8'd0);
`ifdef FIR_ROUND_EN
      rnd_exp = 2;
`else
      rnd_exp = 1;
`endif
      check("round_y", int'(y2), rnd_exp);
      check("noshift_y", int'(y0), 6);
      idle(2);

      // Random traffic: samples, reloads, stray writes, occasional reset.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
             4'($urandom), 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
